wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/argon_bus_pkg.sv | 12 +
 rtl/rr_pick2.sv | 20 ++
 rtl/wb_arbiter.sv | 151 +++++++++++++++
 tb/tb_wb_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/argon_bus_pkg.sv
// Shared types and constants for the argon bus arbiter.
package argon_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam logic [31:0] ARB_TIMEOUT_DATA = 32'h0;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way picker: one-hot winner from two requests.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  input  logic       round_robin,
  output logic [1:0] pick
);

  always_comb begin
    pick = '0;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      // Tie: alternate away from last_owner (1 = m1), or m0 under fixed priority.
      2'b11:   pick = (round_robin && !last_owner) ? 2'b10 : 2'b01;
      default: pick = '0;
    endcase
  end

endmodule

// File: rtl/wb_arbiter.sv
// Two-requester Wishbone arbiter in front of a single shared target, with ack timeout.
module wb_arbiter
  import argon_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          ROUND_ROBIN    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_cycle,
  input  logic        m0_strobe,
  input  logic        m0_write_enable,
  input  logic [31:0] m0_address,
  input  logic [31:0] m0_data_in,
  output logic [31:0] m0_data_out,
  output logic        m0_ack,
  input  logic        m1_cycle,
  input  logic        m1_strobe,
  input  logic        m1_write_enable,
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_data_in,
  output logic [31:0] m1_data_out,
  output logic        m1_ack,
  output logic        s_cycle,
  output logic        s_strobe,
  output logic        s_write_enable,
  output logic [31:0] s_address,
  output logic [31:0] s_data_in,
  input  logic [31:0] s_data_out,
  input  logic        s_ack,
  output logic        bus_timeout,
  output logic [1:0]  grant
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  arb_state_t    state, state_nxt;
  logic [1:0]    owner, owner_nxt;
  logic          last_owner, last_owner_nxt;
  logic [CW-1:0] count, count_nxt;

  logic [1:0]  req, pick;
  logic        busy, timeout_hit;
  logic        own_cyc, own_stb, own_we, own_ack;
  logic [31:0] own_adr, own_din, own_data;

  assign req = {m1_cycle & m1_strobe, m0_cycle & m0_strobe};

  rr_pick2 u_pick (
    .req         (req),
    .last_owner  (last_owner),
    .round_robin (ROUND_ROBIN),
    .pick        (pick)
  );

  // Outputs are gated by reset so nothing leaks while reset is held low.
  assign busy    = reset && (state == BUSY);
  assign own_cyc = owner[1] ? m1_cycle        : m0_cycle;
  assign own_stb = owner[1] ? m1_strobe       : m0_strobe;
  assign own_we  = owner[1] ? m1_write_enable : m0_write_enable;
  assign own_adr = owner[1] ? m1_address      : m0_address;
  assign own_din = owner[1] ? m1_data_in      : m0_data_in;

  always_comb begin
    s_cycle        = 1'b0;
    s_strobe       = 1'b0;
    s_write_enable = 1'b0;
    s_address      = '0;
    s_data_in      = '0;
    m0_ack         = 1'b0;
    m0_data_out    = '0;
    m1_ack         = 1'b0;
    m1_data_out    = '0;
    bus_timeout    = 1'b0;
    grant          = '0;
    timeout_hit    = 1'b0;
    own_ack        = 1'b0;
    own_data       = '0;
    if (busy) begin
      s_cycle        = own_cyc;
      s_strobe       = own_stb;
      s_write_enable = own_we;
      s_address      = own_adr;
      s_data_in      = own_din;
      grant          = owner;
      timeout_hit    = own_cyc && !s_ack && (count == CNT_LAST);
      bus_timeout    = timeout_hit;
      own_ack        = s_ack | timeout_hit;
      own_data       = timeout_hit ? ARB_TIMEOUT_DATA : s_data_out;
      if (owner[0]) begin
        m0_ack      = own_ack;
        m0_data_out = own_data;
      end
      if (owner[1]) begin
        m1_ack      = own_ack;
        m1_data_out = own_data;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    count_nxt      = count;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = BUSY;
          owner_nxt = pick;
          count_nxt = '0;
        end
      end
      BUSY: begin
        if (s_ack) begin
          last_owner_nxt = owner[1];
          state_nxt      = RELEASE;
          owner_nxt      = '0;
        end else if (!own_cyc || timeout_hit) begin
          state_nxt = RELEASE;
          owner_nxt = '0;
        end else if (count != CNT_LAST) begin
          count_nxt = count + 1'b1;
        end
      end
      RELEASE: begin
        if (!s_ack) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        owner_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= 1'b1;
      count      <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      count      <= count_nxt;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: instance 0 is round-robin with an 8-cycle timeout, instance 1 fixed priority.
module tb_wb_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        m0_cycle[2], m0_strobe[2], m0_we[2], m0_ack[2];
  logic [31:0] m0_addr[2], m0_din[2], m0_dout[2];
  logic        m1_cycle[2], m1_strobe[2], m1_we[2], m1_ack[2];
  logic [31:0] m1_addr[2], m1_din[2], m1_dout[2];
  logic        s_cycle[2], s_strobe[2], s_we[2], s_ack[2];
  logic [31:0] s_addr[2], s_din[2], s_dout[2];
  logic        ram_ack[2], inj_ack[2], mute[2], bus_timeout[2];
  logic [1:0]  grant[2];

  typedef struct {
    int          m;
    logic [31:0] data;
    bit          to;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail = 0;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    logic [31:0] mem [64];
    logic        ram_wait;

    wb_arbiter #(.TIMEOUT_CYCLES(k == 0 ? 8 : 255), .ROUND_ROBIN(k == 0)) dut (
      .clk(clk), .reset(reset),
      .m0_cycle(m0_cycle[k]), .m0_strobe(m0_strobe[k]), .m0_write_enable(m0_we[k]),
      .m0_address(m0_addr[k]), .m0_data_in(m0_din[k]), .m0_data_out(m0_dout[k]), .m0_ack(m0_ack[k]),
      .m1_cycle(m1_cycle[k]), .m1_strobe(m1_strobe[k]), .m1_write_enable(m1_we[k]),
      .m1_address(m1_addr[k]), .m1_data_in(m1_din[k]), .m1_data_out(m1_dout[k]), .m1_ack(m1_ack[k]),
      .s_cycle(s_cycle[k]), .s_strobe(s_strobe[k]), .s_write_enable(s_we[k]),
      .s_address(s_addr[k]), .s_data_in(s_din[k]), .s_data_out(s_dout[k]), .s_ack(s_ack[k]),
      .bus_timeout(bus_timeout[k]), .grant(grant[k])
    );

    assign s_ack[k] = ram_ack[k] | inj_ack[k];

    initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | i;
      mem[4] = 32'hCAFE_F00D;
    end

    // Target RAM with one wait state: ack pulses two edges after strobe is first seen.
    always @(posedge clk) begin
      if (!reset) begin
        ram_wait   <= 1'b0;
        ram_ack[k] <= 1'b0;
      end else if (ram_ack[k]) begin
        ram_ack[k] <= 1'b0;
      end else if (s_cycle[k] && s_strobe[k] && !mute[k]) begin
        if (!ram_wait) ram_wait <= 1'b1;
        else begin
          ram_wait   <= 1'b0;
          ram_ack[k] <= 1'b1;
          if (s_we[k]) mem[s_addr[k][7:2]] <= s_din[k];
          else         s_dout[k] <= mem[s_addr[k][7:2]];
        end
      end else begin
        ram_wait <= 1'b0;
      end
    end
  end

  function automatic logic [31:0] exp_mem(input logic [31:0] adr);
    return (adr == 32'h10) ? 32'hCAFE_F00D : (32'hA500_0000 | {26'd0, adr[7:2]});
  endfunction

  task automatic set_m(input int k, input int m, input bit rq, input bit we, input logic [31:0] adr,
                       input logic [31:0] dat);
    if (m == 0) begin
      m0_cycle[k] = rq; m0_strobe[k] = rq; m0_we[k] = we; m0_addr[k] = adr; m0_din[k] = dat;
    end else begin
      m1_cycle[k] = rq; m1_strobe[k] = rq; m1_we[k] = we; m1_addr[k] = adr; m1_din[k] = dat;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      set_m(k, 0, 1'b1, 1'b1, 32'h20, 32'h1);
      set_m(k, 1, 1'b1, 1'b0, 32'h24, 32'h2);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if ({s_cycle[k], s_strobe[k], bus_timeout[k], m0_ack[k], m1_ack[k]} !== 5'b0) begin
          n_fail++;
          $display("FAIL reset_ctrl[%0d]: got cyc/stb/to/ack0/ack1=%b expected 00000", k,
                   {s_cycle[k], s_strobe[k], bus_timeout[k], m0_ack[k], m1_ack[k]});
        end
        n_checks++;
        if (grant[k] !== 2'b00 || m0_dout[k] !== 32'h0 || m1_dout[k] !== 32'h0) begin
          n_fail++;
          $display("FAIL reset_grant_data[%0d]: got grant=%b d0=%h d1=%h expected 00/0/0", k,
                   grant[k], m0_dout[k], m1_dout[k]);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      set_m(k, 0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_m(k, 1, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_read();
    int ack_at = -1;
    int acks = 0;
    bit m0_seen = 1'b0;
    set_m(0, 1, 1'b1, 1'b0, 32'h10, 32'h0);
    sb.push_back('{m: 1, data: exp_mem(32'h10), to: 1'b0});
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_checks++;
        if (grant[0] !== 2'b10 || s_strobe[0] !== 1'b1 || s_addr[0] !== 32'h10) begin
          n_fail++;
          $display("FAIL read_issue: got grant=%b stb=%b adr=%h expected 10/1/00000010",
                   grant[0], s_strobe[0], s_addr[0]);
        end
      end
      if (m0_ack[0]) m0_seen = 1'b1;
      if (m1_ack[0]) begin
        acks++;
        if (ack_at < 0) ack_at = c;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL read_data: got unexpected ack data=%h expected none", m1_dout[0]);
        end else begin
          e = sb.pop_front();
          if (m1_dout[0] !== e.data || e.m != 1) begin
            n_fail++;
            $display("FAIL read_data: got m1 data=%h expected m%0d data=%h", m1_dout[0], e.m, e.data);
          end
        end
        set_m(0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    end
    n_checks++;
    if (ack_at != 3 || acks != 1 || m0_seen) begin
      n_fail++;
      $display("FAIL read_timing: got ack_cycle=%0d acks=%0d m0_ack=%0d expected 3/1/0",
               ack_at, acks, m0_seen);
    end
    repeat (3) @(negedge clk);
  endtask

  // Both masters hold requests; grant order, spacing and returned data go through the scoreboard.
  task automatic test_arbitration(input int k, input int m0_quota, input string tag);
    int done = 0;
    int m0_done = 0;
    int last_start = -1;
    logic [1:0] prev = 2'b00;
    pulse_reset();
    set_m(k, 0, 1'b1, 1'b0, 32'h0, 32'h0);
    set_m(k, 1, 1'b1, 1'b0, 32'h4, 32'h0);
    for (int c = 1; c <= 60 && done < 4; c++) begin
      @(negedge clk);
      if (grant[k] != 2'b00 && prev == 2'b00) begin
        n_checks++;
        if (sb.size() == 0 || grant[k] !== ((sb[0].m == 1) ? 2'b10 : 2'b01)) begin
          n_fail++;
          $display("FAIL %s_grant_order: got grant=%b expected m%0d", tag, grant[k],
                   (sb.size() == 0) ? -1 : sb[0].m);
        end
        if (last_start >= 0) begin
          n_checks++;
          if (c - last_start != 5) begin
            n_fail++;
            $display("FAIL %s_grant_spacing: got %0d cycles expected 5", tag, c - last_start);
          end
        end
        last_start = c;
      end
      prev = grant[k];
      if (m0_ack[k] || m1_ack[k]) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL %s_xfer: got unexpected ack expected none", tag);
        end else begin
          e = sb.pop_front();
          if ((m1_ack[k] ? 1 : 0) != e.m || (m1_ack[k] ? m1_dout[k] : m0_dout[k]) !== e.data) begin
            n_fail++;
            $display("FAIL %s_xfer: got m%0d data=%h expected m%0d data=%h", tag, m1_ack[k] ? 1 : 0,
                     m1_ack[k] ? m1_dout[k] : m0_dout[k], e.m, e.data);
          end
        end
        done++;
        if (m0_ack[k]) m0_done++;
        if (m0_done == m0_quota) set_m(k, 0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    end
    n_checks++;
    if (done != 4) begin
      n_fail++;
      $display("FAIL %s_count: got %0d transfers expected 4", tag, done);
    end
    set_m(k, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m(k, 1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 4; i++)
      sb.push_back('{m: i % 2, data: exp_mem((i % 2 == 1) ? 32'h4 : 32'h0), to: 1'b0});
    test_arbitration(0, 99, "rr");
  endtask

  task automatic test_fixed_priority();
    for (int i = 0; i < 4; i++)
      sb.push_back('{m: (i == 3) ? 1 : 0, data: exp_mem((i == 3) ? 32'h4 : 32'h0), to: 1'b0});
    test_arbitration(1, 3, "fixed");
  endtask

  task automatic test_timeout();
    int to_at = -1;
    int pulses = 0;
    int acks = 0;
    mute[0] = 1'b1;
    sb.push_back('{m: 0, data: 32'h0, to: 1'b1});
    set_m(0, 0, 1'b1, 1'b0, 32'h8, 32'h0);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_checks++;
        if (grant[0] !== 2'b01) begin
          n_fail++;
          $display("FAIL timeout_grant: got %b expected 01", grant[0]);
        end
      end
      if (bus_timeout[0]) begin
        pulses++;
        if (to_at < 0) to_at = c;
      end
      if (m0_ack[0]) begin
        acks++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL timeout_ack: got unexpected ack expected none");
        end else begin
          e = sb.pop_front();
          if (m0_dout[0] !== e.data || bus_timeout[0] !== e.to || c != 8) begin
            n_fail++;
            $display("FAIL timeout_ack: got data=%h to=%b cycle=%0d expected %h/%b/8",
                     m0_dout[0], bus_timeout[0], c, e.data, e.to);
          end
        end
        set_m(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      if (to_at > 0 && c == to_at + 1) begin
        n_checks++;
        if (grant[0] !== 2'b00) begin
          n_fail++;
          $display("FAIL timeout_release: got grant=%b expected 00", grant[0]);
        end
      end
    end
    n_checks++;
    if (pulses != 1 || acks != 1) begin
      n_fail++;
      $display("FAIL timeout_pulse: got pulses=%0d acks=%0d expected 1/1", pulses, acks);
    end
    mute[0] = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    int acks = 0;
    set_m(0, 0, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
    @(negedge clk);
    n_checks++;
    if (grant[0] !== 2'b01 || s_we[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL rstbusy_issue: got grant=%b we=%b expected 01/1", grant[0], s_we[0]);
    end
    reset = 1'b0;
    set_m(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    n_checks++;
    if (s_strobe[0] !== 1'b0 || grant[0] !== 2'b00 || m0_ack[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rstbusy_drop: got stb=%b grant=%b ack=%b expected 0/00/0",
               s_strobe[0], grant[0], m0_ack[0]);
    end
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (m0_ack[0]) acks++;
    end
    n_checks++;
    if (acks != 0 || g_dut[0].mem[8] !== exp_mem(32'h20)) begin
      n_fail++;
      $display("FAIL rstbusy_after: got acks=%0d mem=%h expected 0/%h", acks, g_dut[0].mem[8],
               exp_mem(32'h20));
    end
  endtask

  task automatic test_abort();
    int acks = 0;
    int ack_at = -1;
    set_m(0, 0, 1'b1, 1'b0, 32'hC, 32'h0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (m0_ack[0] || m1_ack[0]) acks++;
      if (c == 1) begin
        n_checks++;
        if (grant[0] !== 2'b01) begin
          n_fail++;
          $display("FAIL abort_grant: got %b expected 01", grant[0]);
        end
        set_m(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      if (c == 2) begin
        n_checks++;
        if (grant[0] !== 2'b00) begin
          n_fail++;
          $display("FAIL abort_release: got grant=%b expected 00", grant[0]);
        end
        inj_ack[0] = 1'b1;
      end
      if (c == 4) inj_ack[0] = 1'b0;
    end
    n_checks++;
    if (acks != 0) begin
      n_fail++;
      $display("FAIL abort_no_ack: got %0d acks expected 0", acks);
    end
    sb.push_back('{m: 1, data: exp_mem(32'h14), to: 1'b0});
    set_m(0, 1, 1'b1, 1'b0, 32'h14, 32'h0);
    for (int c = 1; c <= 10 && ack_at < 0; c++) begin
      @(negedge clk);
      if (m1_ack[0]) begin
        ack_at = c;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL abort_next: got unexpected ack expected none");
        end else begin
          e = sb.pop_front();
          if (m1_dout[0] !== e.data || m0_ack[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_next: got data=%h ack0=%b expected %h/0", m1_dout[0], m0_ack[0], e.data);
          end
        end
        set_m(0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    end
    n_checks++;
    if (ack_at != 3) begin
      n_fail++;
      $display("FAIL abort_next_latency: got ack cycle %0d expected 3", ack_at);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      set_m(k, 0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_m(k, 1, 1'b0, 1'b0, 32'h0, 32'h0);
      inj_ack[k] = 1'b0;
      mute[k] = 1'b0;
    end
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_priority();
    test_timeout();
    test_reset_mid_busy();
    test_abort();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
